mul_issue_ctrl: RTL and testbench

Execute-stage sequencer for the multi-cycle multiplier behind the ALU MUL operation (alucontrol 3'b011).
- Detects a valid MUL in E, starts the multiplier and freezes F/D/E for the multiply latency.
- Injects bubbles into M while frozen, then releases the pipeline with the multiplier result selected.
- Sits between the ALU control pipeline registers and the hazard unit; other ALU ops pass through with zero added latency.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/mul_issue_ctrl_if.sv | 29 ++
 rtl/mul_issue_ctrl_lat.sv | 22 ++
 rtl/mul_issue_ctrl.sv | 107 ++++++++++
 tb/tb_mul_issue_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and multiply-sequencer state encoding.
// Used by the ALU decoder and by the execute-stage multiply sequencer.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } seqState_t;

  // Undefined or unknown encodings fall through to the default and read as non-MUL.
  function automatic logic isMulOp(input logic [2:0] op);
    case (op)
      ALU_MUL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Handshake between the E-stage control registers / hazard unit and the multiply sequencer.
interface mul_issue_ctrl_if #(parameter int CNT_W = 8);

  logic [2:0]       alucontrolE;
  logic             validE;
  logic             flushE;
  logic             mul_start;
  logic             mul_abort;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             bubbleM;
  logic             result_sel;
  logic             busy;
  logic [CNT_W-1:0] mul_count;

  modport master (
    output alucontrolE, validE, flushE,
    input  mul_start, mul_abort, stallF, stallD, stallE, bubbleM,
           result_sel, busy, mul_count
  );

  modport slave (
    input  alucontrolE, validE, flushE,
    output mul_start, mul_abort, stallF, stallD, stallE, bubbleM,
           result_sel, busy, mul_count
  );

endinterface

// File: rtl/mul_issue_ctrl_lat.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module lat_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (!reset)                  cnt <= '0;
    else if (load)               cnt <= loadVal;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Execute-stage sequencer for the multi-cycle multiplier: detects a MUL in E,
// freezes F/D/E with bubbles into M for the latency, then selects the result.
module mul_issue_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  mul_issue_ctrl_if.slave  bus
);

  localparam int CW = $clog2(MUL_LAT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MUL_LAT - 2);

  seqState_t        state, nextState;
  logic             isMul;
  logic             cntLoad, cntDec, cntZero;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] mulCount;
  logic             start, abort, stall, bubble, resultSel, busy;

  assign isMul = bus.validE & isMulOp(bus.alucontrolE) & ~bus.flushE;

  lat_down_counter #(.W(CW)) u_lat (
    .clk     (clk),
    .reset   (reset),
    .load    (cntLoad),
    .loadVal (LOAD_VAL),
    .dec     (cntDec),
    .cnt     (cnt),
    .zero    (cntZero)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (!reset)             mulCount <= '0;
    else if (state == DONE) mulCount <= mulCount + 1'b1;
  end

  always_comb begin
    nextState = state;
    start     = 1'b0;
    abort     = 1'b0;
    stall     = 1'b0;
    bubble    = 1'b0;
    resultSel = 1'b0;
    busy      = 1'b0;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    case (state)
      IDLE: begin
        if (isMul) begin
          start     = 1'b1;
          stall     = 1'b1;
          bubble    = 1'b1;
          cntLoad   = 1'b1;
          nextState = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        // A redirect squashes the MUL: release the pipeline now and drop the operation.
        if (bus.flushE) begin
          abort     = 1'b1;
          nextState = IDLE;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (cntZero) nextState = DONE;
          else         cntDec    = 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        resultSel = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Outputs stay quiet while reset is held, even if E presents a MUL.
    if (!reset) begin
      start     = 1'b0;
      abort     = 1'b0;
      stall     = 1'b0;
      bubble    = 1'b0;
      resultSel = 1'b0;
      busy      = 1'b0;
    end
  end

  assign bus.mul_start  = start;
  assign bus.mul_abort  = abort;
  assign bus.stallF     = stall;
  assign bus.stallD     = stall;
  assign bus.stallE     = stall;
  assign bus.bubbleM    = bubble;
  assign bus.result_sel = resultSel;
  assign bus.busy       = busy;
  assign bus.mul_count  = mulCount;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: one instance at MUL_LAT=4/CNT_W=8, one at MUL_LAT=2/CNT_W=2.
module tb_mul_issue_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset1, reset2;
  int   nCmp = 0;
  int   nErr = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl_if #(.CNT_W(8)) bus1 ();
  mul_issue_ctrl_if #(.CNT_W(2)) bus2 ();

  mul_issue_ctrl #(.MUL_LAT(4), .CNT_W(8)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));
  mul_issue_ctrl #(.MUL_LAT(2), .CNT_W(2)) dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  // {mul_start, mul_abort, stallF, stallD, stallE, bubbleM, result_sel, busy}
  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_START = 8'hBC;
  localparam logic [7:0] O_BUSY  = 8'h3D;
  localparam logic [7:0] O_ABORT = 8'h41;
  localparam logic [7:0] O_DONE  = 8'h03;

  logic [7:0] o1, o2;
  assign o1 = {bus1.mul_start, bus1.mul_abort, bus1.stallF, bus1.stallD, bus1.stallE,
               bus1.bubbleM, bus1.result_sel, bus1.busy};
  assign o2 = {bus2.mul_start, bus2.mul_abort, bus2.stallF, bus2.stallD, bus2.stallE,
               bus2.bubbleM, bus2.result_sel, bus2.busy};

  task automatic drive1(input logic [2:0] op, input logic v, input logic f);
    bus1.alucontrolE = op;
    bus1.validE      = v;
    bus1.flushE      = f;
  endtask

  task automatic drive2(input logic [2:0] op, input logic v, input logic f);
    bus2.alucontrolE = op;
    bus2.validE      = v;
    bus2.flushE      = f;
  endtask

  task automatic test_reset();
    reset1 = 1'b0;
    reset2 = 1'b0;
    drive1(ALU_MUL, 1'b1, 1'b0);
    drive2(ALU_MUL, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nCmp++;
      if (o1 !== O_NONE) begin nErr++; $display("FAIL reset_out1 cyc%0d got=%h exp=%h", i, o1, O_NONE); end
      nCmp++;
      if (o2 !== O_NONE) begin nErr++; $display("FAIL reset_out2 cyc%0d got=%h exp=%h", i, o2, O_NONE); end
      if (i == 1) begin
        nCmp++;
        if (bus1.mul_count !== 8'd0) begin nErr++; $display("FAIL reset_count1 got=%0d exp=0", bus1.mul_count); end
        nCmp++;
        if (bus2.mul_count !== 2'd0) begin nErr++; $display("FAIL reset_count2 got=%0d exp=0", bus2.mul_count); end
      end
      @(posedge clk); #1;
    end
    reset1 = 1'b1;
    reset2 = 1'b1;
    @(negedge clk);
    nCmp++;
    if (o1 !== O_START) begin nErr++; $display("FAIL reset_release_start1 got=%h exp=%h", o1, O_START); end
    nCmp++;
    if (o2 !== O_START) begin nErr++; $display("FAIL reset_release_start2 got=%h exp=%h", o2, O_START); end
    @(posedge clk); #1;
    // Both now in BUSY; reset again with no abort expected.
    reset1 = 1'b0;
    reset2 = 1'b0;
    drive1(ALU_ADD, 1'b0, 1'b0);
    drive2(ALU_ADD, 1'b0, 1'b0);
    @(negedge clk);
    nCmp++;
    if (o1 !== O_NONE) begin nErr++; $display("FAIL reset_in_busy1 got=%h exp=%h", o1, O_NONE); end
    @(posedge clk); #1;
    reset1 = 1'b1;
    reset2 = 1'b1;
  endtask

  task automatic test_single_mul();
    logic [7:0] exp [0:5] = '{O_START, O_BUSY, O_BUSY, O_BUSY, O_DONE, O_NONE};
    for (int i = 0; i < 6; i++) begin
      drive1(ALU_MUL, (i < 5), 1'b0);
      @(negedge clk);
      nCmp++;
      if (o1 !== exp[i]) begin nErr++; $display("FAIL single_mul cyc%0d got=%h exp=%h", i, o1, exp[i]); end
      @(posedge clk); #1;
    end
    nCmp++;
    if (bus1.mul_count !== 8'd1) begin nErr++; $display("FAIL single_mul_count got=%0d exp=1", bus1.mul_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [0:10] = '{O_START, O_BUSY, O_BUSY, O_BUSY, O_DONE,
                               O_START, O_BUSY, O_BUSY, O_BUSY, O_DONE, O_NONE};
    for (int i = 0; i < 11; i++) begin
      drive1(ALU_MUL, (i < 10), 1'b0);
      @(negedge clk);
      nCmp++;
      if (o1 !== exp[i]) begin nErr++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, o1, exp[i]); end
      @(posedge clk); #1;
    end
    nCmp++;
    if (bus1.mul_count !== 8'd3) begin nErr++; $display("FAIL back_to_back_count got=%0d exp=3", bus1.mul_count); end
  endtask

  task automatic test_flush();
    logic [7:0] exp [0:4] = '{O_START, O_BUSY, O_ABORT, O_NONE, O_NONE};
    for (int i = 0; i < 5; i++) begin
      drive1(ALU_MUL, (i < 3), (i == 2));
      @(negedge clk);
      nCmp++;
      if (o1 !== exp[i]) begin nErr++; $display("FAIL flush cyc%0d got=%h exp=%h", i, o1, exp[i]); end
      @(posedge clk); #1;
    end
    nCmp++;
    if (bus1.mul_count !== 8'd3) begin nErr++; $display("FAIL flush_count got=%0d exp=3", bus1.mul_count); end
  endtask

  task automatic test_non_mul();
    logic [2:0] ops [0:6] = '{ALU_ADD, ALU_SUB, ALU_MUL, ALU_MUL, 3'b111, 3'bxxx, 3'b0x1};
    logic       vs  [0:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       fs  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive1(ops[i], vs[i], fs[i]);
      @(negedge clk);
      nCmp++;
      if (o1 !== O_NONE) begin nErr++; $display("FAIL non_mul vec%0d got=%h exp=%h", i, o1, O_NONE); end
      @(posedge clk); #1;
    end
    drive1(ALU_ADD, 1'b0, 1'b0);
  endtask

  task automatic test_lat2_wrap();
    logic [7:0] exp [0:2] = '{O_START, O_BUSY, O_DONE};
    for (int i = 0; i < 15; i++) begin
      drive2(ALU_MUL, 1'b1, 1'b0);
      @(negedge clk);
      nCmp++;
      if (o2 !== exp[i % 3]) begin nErr++; $display("FAIL lat2_seq cyc%0d got=%h exp=%h", i, o2, exp[i % 3]); end
      if (i == 12) begin
        nCmp++;
        if (bus2.mul_count !== 2'd0) begin nErr++; $display("FAIL lat2_wrap_count got=%0d exp=0", bus2.mul_count); end
      end
      @(posedge clk); #1;
    end
    drive2(ALU_ADD, 1'b0, 1'b0);
    @(negedge clk);
    nCmp++;
    if (bus2.mul_count !== 2'd1) begin nErr++; $display("FAIL lat2_final_count got=%0d exp=1", bus2.mul_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy();
    logic [7:0] exp [0:5] = '{O_START, O_NONE, O_NONE, O_START, O_BUSY, O_DONE};
    for (int i = 0; i < 6; i++) begin
      reset2 = (i != 1);
      drive2(ALU_MUL, (i != 2), (i == 1));
      @(negedge clk);
      nCmp++;
      if (o2 !== exp[i]) begin nErr++; $display("FAIL reset_busy cyc%0d got=%h exp=%h", i, o2, exp[i]); end
      if (i == 2) begin
        nCmp++;
        if (bus2.mul_count !== 2'd0) begin nErr++; $display("FAIL reset_busy_count got=%0d exp=0", bus2.mul_count); end
      end
      @(posedge clk); #1;
    end
    drive2(ALU_ADD, 1'b0, 1'b0);
    nCmp++;
    if (bus2.mul_count !== 2'd1) begin nErr++; $display("FAIL reset_busy_after got=%0d exp=1", bus2.mul_count); end
  endtask

  initial begin
    test_reset();
    test_single_mul();
    test_back_to_back();
    test_flush();
    test_non_mul();
    test_lat2_wrap();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
